uart_tx_port: RTL



---
 rtl/uart_tx_port.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// A store to TX_ADDR queues RegData. A store to STAT_ADDR clears the overflow flag.
// A read at STAT_ADDR returns {4'b0, empty, ovf, busy, full}; any other address
// passes MemData through unchanged.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   Address, RegData  bus address and store data
//   we                store strobe, one cycle per store
//   MemData, RdData   data-memory read data in, read-mux data out
//   tx                serial line, idle high
//   busy, full        transmitter/FIFO status
module uart_tx_port #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  TX_ADDR   = 8'hFF,
    parameter logic [7:0]  STAT_ADDR = 8'hFE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Address,
    input  logic [7:0] RegData,
    input  logic       we,
    input  logic [7:0] MemData,
    output logic [7:0] RdData,
    output logic       tx,
    output logic       busy,
    output logic       full
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [2:0]      bidx, bidx_n;
    logic [7:0]      sh, sh_n;
    logic            tx_n;
    logic [CW-1:0]   count, count_n;
    logic [AW-1:0]   wptr, rptr;
    logic            ovf, ovf_n;
    logic            empty;
    logic [7:0]      mem [DEPTH];

    logic            tx_sel, stat_sel, push, drop, pop, bit_end;

    // Bus decode; full is judged on the pre-edge count so a push while full drops
    always_comb begin
        tx_sel   = we && (Address == TX_ADDR);
        stat_sel = we && (Address == STAT_ADDR);
        push     = tx_sel && (count != CW'(DEPTH));
        drop     = tx_sel && (count == CW'(DEPTH));
        bit_end  = (bcnt == BW'(DIV - 1));
    end

    // Status read mux
    always_comb begin
        if (Address == STAT_ADDR) begin
            RdData = {4'b0000, empty, ovf, busy, full};
        end else begin
            RdData = MemData;
        end
    end

    // Frame sequencer: next state, FIFO pop and next line level
    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        bidx_n  = bidx;
        sh_n    = sh;
        pop     = 1'b0;
        tx_n    = 1'b1;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    sh_n    = mem[rptr];
                    bcnt_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bcnt_n  = '0;
                    bidx_n  = 3'd0;
                    state_n = DATA;
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bcnt_n = '0;
                    sh_n   = {1'b0, sh[7:1]};
                    if (bidx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bidx_n = bidx + 3'd1;
                    end
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    bcnt_n = '0;
                    // Chain straight into the next start bit when data is waiting
                    if (count != '0) begin
                        pop     = 1'b1;
                        sh_n    = mem[rptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_n[0];
            default: tx_n = 1'b1;
        endcase

        count_n = count + CW'(push) - CW'(pop);

        // A dropped push wins over a clear
        if (drop) begin
            ovf_n = 1'b1;
        end else if (stat_sel) begin
            ovf_n = 1'b0;
        end else begin
            ovf_n = ovf;
        end
    end

    // State, FIFO bookkeeping and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bcnt  <= '0;
            bidx  <= 3'd0;
            sh    <= 8'h00;
            tx    <= 1'b1;
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            state <= state_n;
            bcnt  <= bcnt_n;
            bidx  <= bidx_n;
            sh    <= sh_n;
            tx    <= tx_n;
            count <= count_n;
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            ovf   <= ovf_n;
            busy  <= (state_n != IDLE) || (count_n != '0);
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= RegData;
        end
    end

endmodule
